// File: rtl/hist_bin_bank.sv
// Bank of DEPTH saturating histogram bins with direct write, weighted increment,
// a registered random-read port and a ready/valid dump sequencer.
module hist_bin_bank #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AW          = $clog2(DEPTH),
  parameter int unsigned WW          = 8,
  parameter bit          CLR_ON_DUMP = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             inc_valid,
  input  logic [AW-1:0]    inc_addr,
  input  logic [WW-1:0]    inc_weight,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             sat_flag,
  input  logic             sat_clr,
  input  logic             dump_start,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [WIDTH-1:0] dump_data,
  output logic [AW-1:0]    dump_idx,
  output logic             dump_last,
  output logic             dump_busy,
  output logic             dump_done
);

  typedef enum logic {StIdle, StDump} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bins_q [DEPTH];
  logic [WIDTH-1:0] bins_d [DEPTH];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             sat_q, sat_d, sat_set;
  logic [AW-1:0]    idx_q, idx_d;
  logic             done_q, done_d;
  logic             busy, last, hs;
  logic [WIDTH-1:0] base;
  logic [WIDTH:0]   sum;

  assign busy = (state_q == StDump);
  assign last = (idx_q == AW'(DEPTH - 1));
  assign hs   = busy & dump_ready;

  // Per-bin update: write beats increment; a dump hand-off zeroes the bin
  // underneath, so a same-cycle increment starts from zero.
  always_comb begin
    bins_d  = bins_q;
    sat_set = 1'b0;
    base    = '0;
    sum     = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (CLR_ON_DUMP && hs && (idx_q == AW'(i))) begin
        base      = '0;
        bins_d[i] = '0;
      end else begin
        base = bins_q[i];
      end
      sum = {1'b0, base} + (WIDTH + 1)'(inc_weight);
      if (we && (waddr == AW'(i))) begin
        bins_d[i] = wdata;
      end else if (inc_valid && (inc_addr == AW'(i))) begin
        if (sum[WIDTH]) begin
          bins_d[i] = '1;
          sat_set   = 1'b1;
        end else begin
          bins_d[i] = sum[WIDTH-1:0];
        end
      end
    end
  end

  always_comb begin
    rd_data_d = (32'(rd_addr) < DEPTH) ? bins_q[rd_addr] : '0;
    sat_d     = sat_set ? 1'b1 : (sat_clr ? 1'b0 : sat_q);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dump_start) begin
          state_d = StDump;
          idx_d   = '0;
        end
      end
      StDump: begin
        if (dump_ready) begin
          if (last) begin
            state_d = StIdle;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        bins_q[i] <= '0;
      end
      rd_data_q <= '0;
      sat_q     <= 1'b0;
      state_q   <= StIdle;
      idx_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      bins_q    <= bins_d;
      rd_data_q <= rd_data_d;
      sat_q     <= sat_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign sat_flag   = sat_q;
  assign dump_valid = busy;
  assign dump_busy  = busy;
  assign dump_idx   = idx_q;
  assign dump_data  = bins_q[idx_q];
  assign dump_last  = busy & last;
  assign dump_done  = done_q;

endmodule

// File: tb/tb_hist_bin_bank.sv
// Directed self-checking bench for hist_bin_bank (8-bit bins, 16 deep, clear-on-dump).
module tb_hist_bin_bank;

  localparam int W = 8;
  localparam int D = 16;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         clr, we, inc_valid, sat_clr, dump_start, dump_ready;
  logic [A-1:0] waddr, inc_addr, rd_addr;
  logic [W-1:0] wdata, inc_weight;
  logic [W-1:0] rd_data, dump_data;
  logic [A-1:0] dump_idx;
  logic         sat_flag, dump_valid, dump_last, dump_busy, dump_done;

  int n_cmp = 0;
  int n_err = 0;

  hist_bin_bank #(
    .WIDTH(W), .DEPTH(D), .AW(A), .WW(8), .CLR_ON_DUMP(1'b1)
  ) dut (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .inc_valid(inc_valid), .inc_addr(inc_addr), .inc_weight(inc_weight),
    .rd_addr(rd_addr), .rd_data(rd_data), .sat_flag(sat_flag), .sat_clr(sat_clr),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_idx(dump_idx), .dump_last(dump_last),
    .dump_busy(dump_busy), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [A-1:0] a, input logic [W-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input logic [A-1:0] a, output logic [W-1:0] v);
    rd_addr = a;
    step();
    v = rd_data;
  endtask

  // Streams beats until the sequencer goes idle; bounded.
  task automatic finish_dump();
    int n = 0;
    dump_ready = 1'b1;
    while (dump_busy === 1'b1 && n < 40) begin
      step();
      n++;
    end
    dump_ready = 1'b0;
    n_cmp++;
    if (dump_busy !== 1'b0) begin
      n_err++; $display("FAIL finish_dump: busy=%b required 0", dump_busy);
    end
  endtask

  task automatic wait_idx(input logic [A-1:0] target);
    int n = 0;
    dump_ready = 1'b1;
    while (dump_idx !== target && n < 40) begin
      step();
      n++;
    end
    dump_ready = 1'b0;
    n_cmp++;
    if (dump_idx !== target) begin
      n_err++; $display("FAIL wait_idx: idx=%0d required %0d", dump_idx, target);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_cmp++;
    if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd: %h required 00", rd_data); end
    n_cmp++;
    if (sat_flag !== 1'b0) begin n_err++; $display("FAIL reset_sat: %b required 0", sat_flag); end
    n_cmp++;
    if ({dump_valid, dump_busy, dump_done} !== 3'b000) begin
      n_err++; $display("FAIL reset_dump: v/b/d=%b required 000", {dump_valid, dump_busy, dump_done});
    end
    n_cmp++;
    if (dump_idx !== 4'd0) begin n_err++; $display("FAIL reset_idx: %0d required 0", dump_idx); end
  endtask

  task automatic test_read();
    logic [W-1:0] v;
    wr(4'd3, 8'h10);
    rd(4'd3, v);
    n_cmp++;
    if (v !== 8'h10) begin n_err++; $display("FAIL read_bin3: %h required 10", v); end
    we = 1'b1; waddr = 4'd3; wdata = 8'h20; rd_addr = 4'd3;
    step();
    we = 1'b0;
    n_cmp++;
    if (rd_data !== 8'h10) begin n_err++; $display("FAIL read_old: %h required 10", rd_data); end
    step();
    n_cmp++;
    if (rd_data !== 8'h20) begin n_err++; $display("FAIL read_new: %h required 20", rd_data); end
  endtask

  task automatic test_saturate();
    logic [W-1:0] v;
    wr(4'd5, 8'hFA);
    inc_valid = 1'b1; inc_addr = 4'd5; inc_weight = 8'd10;
    step();
    inc_valid = 1'b0;
    n_cmp++;
    if (sat_flag !== 1'b1) begin n_err++; $display("FAIL sat_set: %b required 1", sat_flag); end
    rd(4'd5, v);
    n_cmp++;
    if (v !== 8'hFF) begin n_err++; $display("FAIL sat_value: %h required ff", v); end
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    n_cmp++;
    if (sat_flag !== 1'b0) begin n_err++; $display("FAIL sat_clr: %b required 0", sat_flag); end
    // 0xFF + 0 reaches but does not exceed max
    inc_valid = 1'b1; inc_addr = 4'd5; inc_weight = 8'd0;
    step();
    n_cmp++;
    if (sat_flag !== 1'b0) begin n_err++; $display("FAIL sat_w0: %b required 0", sat_flag); end
    wr(4'd1, 8'h10);
    inc_valid = 1'b1; inc_addr = 4'd1; inc_weight = 8'd5;
    step();
    inc_valid = 1'b0;
    rd(4'd1, v);
    n_cmp++;
    if (v !== 8'h15 || sat_flag !== 1'b0) begin
      n_err++; $display("FAIL inc_plain: %h sat=%b required 15 sat=0", v, sat_flag);
    end
    sat_clr = 1'b1; inc_valid = 1'b1; inc_addr = 4'd5; inc_weight = 8'd1;
    step();
    sat_clr = 1'b0; inc_valid = 1'b0;
    n_cmp++;
    if (sat_flag !== 1'b1) begin n_err++; $display("FAIL sat_set_wins: %b required 1", sat_flag); end
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
  endtask

  task automatic test_priority();
    logic [W-1:0] v;
    wr(4'd2, 8'hFF);
    we = 1'b1; waddr = 4'd2; wdata = 8'h07;
    inc_valid = 1'b1; inc_addr = 4'd2; inc_weight = 8'd3;
    step();
    we = 1'b0; inc_valid = 1'b0;
    rd(4'd2, v);
    n_cmp++;
    if (v !== 8'h07) begin n_err++; $display("FAIL prio_we: %h required 07", v); end
    n_cmp++;
    if (sat_flag !== 1'b0) begin n_err++; $display("FAIL prio_sat: %b required 0", sat_flag); end
    we = 1'b1; waddr = 4'd4; wdata = 8'h44;
    inc_valid = 1'b1; inc_addr = 4'd2; inc_weight = 8'd3;
    step();
    we = 1'b0; inc_valid = 1'b0;
    rd(4'd2, v);
    n_cmp++;
    if (v !== 8'h0A) begin n_err++; $display("FAIL indep_inc: %h required 0a", v); end
    rd(4'd4, v);
    n_cmp++;
    if (v !== 8'h44) begin n_err++; $display("FAIL indep_we: %h required 44", v); end
  endtask

  task automatic test_dump();
    logic [W-1:0] v;
    int beats = 0;
    int dones = 0;
    int errs  = 0;
    for (int i = 0; i < D; i++) wr(A'(i), W'(i + 1));
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (int cyc = 0; cyc < 100 && beats < D; cyc++) begin
      dump_ready = cyc[0];
      n_cmp++;
      if (dump_valid !== 1'b1 || dump_busy !== 1'b1 || dump_idx !== A'(beats) ||
          dump_data !== W'(beats + 1) || dump_last !== (beats == D - 1) || dump_done !== 1'b0) begin
        n_err++;
        $display("FAIL dump_beat%0d: v=%b b=%b idx=%0d data=%h last=%b done=%b required idx=%0d data=%h",
                 beats, dump_valid, dump_busy, dump_idx, dump_data, dump_last, dump_done,
                 beats, beats + 1);
      end
      if (dump_ready) beats++;
      step();
    end
    dump_ready = 1'b0;
    n_cmp++;
    if (beats != D) begin n_err++; $display("FAIL dump_count: %0d required %0d", beats, D); end
    if (dump_done === 1'b1) dones++;
    n_cmp++;
    if ({dump_busy, dump_valid} !== 2'b00) begin
      n_err++; $display("FAIL dump_idle: busy/valid=%b required 00", {dump_busy, dump_valid});
    end
    step();
    if (dump_done === 1'b1) dones++;
    n_cmp++;
    if (dones != 1) begin n_err++; $display("FAIL dump_done_pulses: %0d required 1", dones); end
    for (int i = 0; i < D; i++) begin
      rd(A'(i), v);
      if (v !== 8'h00) errs++;
    end
    n_cmp++;
    if (errs != 0) begin n_err++; $display("FAIL dump_cleared: %0d nonzero bins required 0", errs); end
  endtask

  task automatic test_dump_collide();
    logic [W-1:0] v;
    wr(4'd6, 8'h33);
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    wait_idx(4'd6);
    n_cmp++;
    if (dump_data !== 8'h33) begin n_err++; $display("FAIL coll_data: %h required 33", dump_data); end
    dump_ready = 1'b1; inc_valid = 1'b1; inc_addr = 4'd6; inc_weight = 8'd4;
    step();
    dump_ready = 1'b0; inc_valid = 1'b0;
    rd(4'd6, v);
    n_cmp++;
    if (v !== 8'h04) begin n_err++; $display("FAIL coll_inc: %h required 04", v); end
    finish_dump();
    wr(4'd6, 8'h33);
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    wait_idx(4'd6);
    dump_ready = 1'b1; we = 1'b1; waddr = 4'd6; wdata = 8'h09;
    step();
    dump_ready = 1'b0; we = 1'b0;
    rd(4'd6, v);
    n_cmp++;
    if (v !== 8'h09) begin n_err++; $display("FAIL coll_we: %h required 09", v); end
    finish_dump();
    step();
  endtask

  task automatic test_clr_abort();
    logic [W-1:0] v;
    int errs  = 0;
    int dones = 0;
    wr(4'd9, 8'h05);
    wr(4'd15, 8'hAB);
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    wait_idx(4'd8);
    clr = 1'b1;
    step();
    clr = 1'b0;
    if (dump_done === 1'b1) dones++;
    n_cmp++;
    if ({dump_valid, dump_busy} !== 2'b00 || dump_idx !== 4'd0) begin
      n_err++; $display("FAIL abort_state: v/b=%b idx=%0d required 00 idx=0",
                        {dump_valid, dump_busy}, dump_idx);
    end
    step();
    if (dump_done === 1'b1) dones++;
    n_cmp++;
    if (dones != 0) begin n_err++; $display("FAIL abort_done: %0d pulses required 0", dones); end
    for (int i = 0; i < D; i++) begin
      rd(A'(i), v);
      if (v !== 8'h00) errs++;
    end
    n_cmp++;
    if (errs != 0) begin n_err++; $display("FAIL abort_bins: %0d nonzero required 0", errs); end
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    n_cmp++;
    if (dump_valid !== 1'b1 || dump_idx !== 4'd0) begin
      n_err++; $display("FAIL restart: valid=%b idx=%0d required 1 idx=0", dump_valid, dump_idx);
    end
    finish_dump();
  endtask

  initial begin
    clr = 1'b0; we = 1'b0; inc_valid = 1'b0; sat_clr = 1'b0;
    dump_start = 1'b0; dump_ready = 1'b0;
    waddr = '0; inc_addr = '0; rd_addr = '0; wdata = '0; inc_weight = '0;
    test_reset();
    test_read();
    test_saturate();
    test_priority();
    test_dump();
    test_dump_collide();
    test_clr_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
